gat_layer_sched: RTL and testbench

Top-level layer scheduler for the two-layer GAT accelerator. It waits for the host to finish loading the H-data, node-info and weight BRAMs, then starts `gat_conv1`. It hands the new-feature BRAM over to `gat_conv2`, starts that layer, and raises `gat_ready` when inference completes. It also exports per-layer cycle counts and a watchdog status on the `gat_debug_*` register-bank words.

---
 rtl/gat_pkg.sv | 27 ++
 rtl/gat_layer_sched_if.sv | 20 ++
 rtl/gat_layer_sched_cycle_counter.sv | 73 +++++++
 rtl/gat_layer_sched.sv | 147 ++++++++++++++
 tb/tb_gat_layer_sched.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gat_pkg.sv
// Shared types and constants for the GAT accelerator layer scheduler.
package gat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_RUN1 = 3'd2,
    ST_XFER = 3'd3,
    ST_RUN2 = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } sched_state_e;

  localparam int SCHED_XFER_CYCLES = 2;
  localparam int LAT1_W            = 16;
  localparam int LAT2_W            = 12;
  localparam int DBG3_W            = LAT1_W + LAT2_W + 1 + 3;

  // Layout of the third debug word as seen by the host.
  function automatic logic [DBG3_W-1:0] sched_dbg3(input logic [LAT1_W-1:0] lat1,
                                                   input logic [LAT2_W-1:0] lat2,
                                                   input logic              err,
                                                   input sched_state_e      st);
    return {lat1, lat2, err, st};
  endfunction

endpackage

// File: rtl/gat_layer_sched_if.sv
// Handshake bundle between the layer scheduler and the two convolution layers.
interface gat_layer_sched_if;
  logic conv1_start_o;
  logic conv2_start_o;
  logic feat_owner_o;
  logic conv1_done_i;
  logic conv2_done_i;
  logic conv1_first_feat_i;
  logic conv2_first_feat_i;

  modport master (
    output conv1_start_o, conv2_start_o, feat_owner_o,
    input  conv1_done_i, conv2_done_i, conv1_first_feat_i, conv2_first_feat_i
  );

  modport slave (
    input  conv1_start_o, conv2_start_o, feat_owner_o,
    output conv1_done_i, conv2_done_i, conv1_first_feat_i, conv2_first_feat_i
  );
endinterface

// File: rtl/gat_layer_sched_cycle_counter.sv
// Saturating cycle counter with load-to-1 and two first-event capture registers
// that snapshot the counter value (truncated) on the first event after a clear.
module sched_cycle_counter #(
  parameter int W       = 32,
  parameter int CAP_A_W = 16,
  parameter int CAP_B_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               inc_i,
  input  logic [1:0]         cap_clr_i,
  input  logic [1:0]         cap_evt_i,
  output logic [W-1:0]       cnt_o,
  output logic [CAP_A_W-1:0] cap_a_o,
  output logic [CAP_B_W-1:0] cap_b_o
);

  logic [W-1:0]       cnt_q, cnt_d;
  logic [CAP_A_W-1:0] cap_a_q, cap_a_d;
  logic [CAP_B_W-1:0] cap_b_q, cap_b_d;
  logic [1:0]         seen_q, seen_d;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)     cnt_d = {{(W-1){1'b0}}, 1'b1};
    else if (inc_i) cnt_d = sat_inc(cnt_q);
  end

  // Clear has priority over an event on the same cycle.
  always_comb begin
    seen_d  = seen_q;
    cap_a_d = cap_a_q;
    cap_b_d = cap_b_q;
    if (cap_clr_i[0]) begin
      seen_d[0] = 1'b0;
      cap_a_d   = '0;
    end else if (cap_evt_i[0] && !seen_q[0]) begin
      seen_d[0] = 1'b1;
      cap_a_d   = cnt_q[CAP_A_W-1:0];
    end
    if (cap_clr_i[1]) begin
      seen_d[1] = 1'b0;
      cap_b_d   = '0;
    end else if (cap_evt_i[1] && !seen_q[1]) begin
      seen_d[1] = 1'b1;
      cap_b_d   = cnt_q[CAP_B_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      seen_q  <= '0;
      cap_a_q <= '0;
      cap_b_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      cap_a_q <= cap_a_d;
      cap_b_q <= cap_b_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign cap_a_o = cap_a_q;
  assign cap_b_o = cap_b_q;

endmodule

// File: rtl/gat_layer_sched.sv
// Two-layer GAT scheduler: waits for a fresh "all BRAMs loaded" edge, sequences
// conv1 -> feature hand-over -> conv2, and exports cycle counts plus watchdog status.
module gat_layer_sched
  import gat_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2**28,
  parameter int          CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               h_data_bram_load_done,
  input  logic               h_node_info_bram_load_done,
  input  logic               wgt_bram_load_done,
  gat_layer_sched_if.master  conv,
  output logic               gat_ready,
  output logic [CNT_W-1:0]   gat_debug_1,
  output logic [CNT_W-1:0]   gat_debug_2,
  output logic [CNT_W-1:0]   gat_debug_3
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [1:0]       XFER_LAST   = 2'(SCHED_XFER_CYCLES - 1);

  sched_state_e       state_q, state_d;
  logic               all_loaded_q;
  logic [1:0]         xfer_cnt_q, xfer_cnt_d;
  logic               start1_q, start1_d;
  logic               start2_q, start2_d;
  logic               owner_q, owner_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   dbg1_q, dbg1_d;
  logic [CNT_W-1:0]   dbg2_q, dbg2_d;
  logic [CNT_W-1:0]   run_cnt;
  logic [LAT1_W-1:0]  lat1;
  logic [LAT2_W-1:0]  lat2;
  logic               in_run;
  logic               timeout_hit;

  assign in_run = (state_q == ST_RUN1) || (state_q == ST_RUN2);
  // On a start cycle the counter still holds the previous run's value.
  assign timeout_hit = !(start1_q || start2_q) && (run_cnt >= TIMEOUT_VAL);

  sched_cycle_counter #(
    .W       (CNT_W),
    .CAP_A_W (LAT1_W),
    .CAP_B_W (LAT2_W)
  ) u_run_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (start1_q || start2_q),
    .inc_i     (in_run),
    .cap_clr_i ({start1_q, start1_q}),
    .cap_evt_i ({conv.conv2_first_feat_i && (state_q == ST_RUN2),
                 conv.conv1_first_feat_i && (state_q == ST_RUN1)}),
    .cnt_o     (run_cnt),
    .cap_a_o   (lat1),
    .cap_b_o   (lat2)
  );

  always_comb begin
    state_d    = state_q;
    xfer_cnt_d = xfer_cnt_q;
    start1_d   = 1'b0;
    start2_d   = 1'b0;
    err_d      = err_q;
    dbg1_d     = dbg1_q;
    dbg2_d     = dbg2_q;
    unique case (state_q)
      ST_IDLE: if (!all_loaded_q) state_d = ST_ARM;
      ST_ARM: begin
        if (all_loaded_q) begin
          state_d  = ST_RUN1;
          start1_d = 1'b1;
          err_d    = 1'b0;
        end
      end
      ST_RUN1: begin
        if (conv.conv1_done_i) begin
          state_d    = ST_XFER;
          dbg1_d     = run_cnt;
          xfer_cnt_d = '0;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end
      end
      ST_XFER: begin
        if (xfer_cnt_q == XFER_LAST) begin
          state_d  = ST_RUN2;
          start2_d = 1'b1;
        end else begin
          xfer_cnt_d = xfer_cnt_q + 2'd1;
        end
      end
      ST_RUN2: begin
        if (conv.conv2_done_i) begin
          state_d = ST_DONE;
          dbg2_d  = run_cnt;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end
      end
      ST_DONE, ST_ERR: if (!all_loaded_q) state_d = ST_ARM;
      default: state_d = ST_IDLE;
    endcase
    owner_d = (state_d == ST_XFER) || (state_d == ST_RUN2) || (state_d == ST_DONE);
    ready_d = (state_d == ST_DONE) || (state_d == ST_ERR);
  end

  // all_loaded resets high so flags already set at reset release need a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      all_loaded_q <= 1'b1;
      xfer_cnt_q   <= '0;
      start1_q     <= 1'b0;
      start2_q     <= 1'b0;
      owner_q      <= 1'b0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      dbg1_q       <= '0;
      dbg2_q       <= '0;
    end else begin
      state_q      <= state_d;
      all_loaded_q <= h_data_bram_load_done && h_node_info_bram_load_done && wgt_bram_load_done;
      xfer_cnt_q   <= xfer_cnt_d;
      start1_q     <= start1_d;
      start2_q     <= start2_d;
      owner_q      <= owner_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      dbg1_q       <= dbg1_d;
      dbg2_q       <= dbg2_d;
    end
  end

  assign conv.conv1_start_o = start1_q;
  assign conv.conv2_start_o = start2_q;
  assign conv.feat_owner_o  = owner_q;
  assign gat_ready          = ready_q;
  assign gat_debug_1        = dbg1_q;
  assign gat_debug_2        = dbg2_q;
  assign gat_debug_3        = CNT_W'(sched_dbg3(lat1, lat2, err_q, state_q));

endmodule

// File: tb/tb_gat_layer_sched.sv
// Directed + randomized bench for gat_layer_sched with a cycle-level reference model.
module tb_gat_layer_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        fl_h, fl_n, fl_w, tf;
  logic        ready, t_ready;
  logic [31:0] dbg1, dbg2, dbg3, t_dbg1, t_dbg2, t_dbg3;

  int total = 0;
  int bad   = 0;
  int last_n2 = 0;

  gat_layer_sched_if bus ();
  gat_layer_sched_if tbus ();

  gat_layer_sched #(.TIMEOUT_CYCLES(100000), .CNT_W(32)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .h_data_bram_load_done      (fl_h),
    .h_node_info_bram_load_done (fl_n),
    .wgt_bram_load_done         (fl_w),
    .conv                       (bus),
    .gat_ready                  (ready),
    .gat_debug_1                (dbg1),
    .gat_debug_2                (dbg2),
    .gat_debug_3                (dbg3)
  );

  gat_layer_sched #(.TIMEOUT_CYCLES(64), .CNT_W(32)) dut_t (
    .clk                        (clk),
    .rst                        (rst),
    .h_data_bram_load_done      (tf),
    .h_node_info_bram_load_done (tf),
    .wgt_bram_load_done         (tf),
    .conv                       (tbus),
    .gat_ready                  (t_ready),
    .gat_debug_1                (t_dbg1),
    .gat_debug_2                (t_dbg2),
    .gat_debug_3                (t_dbg3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_dbg3(input int l1, input int l2, input bit e, input int st);
    return {l1[15:0], l2[11:0], e, st[2:0]};
  endfunction

  task automatic set_flags(input logic v);
    fl_h = v; fl_n = v; fl_w = v;
  endtask

  // Flags were raised in the current cycle; expect start two cycles later,
  // then drive a full inference with done pulses n1 / n2 cycles after each start.
  task automatic do_run(input int n1, input int n2, input int f1a, input int f1b,
                        input int f2a, input bit spurious);
    step;
    chk("pre_start1", bus.conv1_start_o, 0);
    step;
    chk("start1", bus.conv1_start_o, 1);
    chk("state_run1", dbg3[2:0], 2);
    for (int k = 1; k <= n1; k++) begin
      step;
      bus.conv1_first_feat_i = (k == f1a) || (k == f1b);
      bus.conv1_done_i       = (k == n1);
      bus.conv2_done_i       = spurious && (k == n1 / 2);
      if (spurious && k == n1 / 3)     set_flags(1'b0);
      if (spurious && k == n1 / 3 + 3) set_flags(1'b1);
    end
    step;
    bus.conv1_first_feat_i = 1'b0;
    bus.conv1_done_i       = 1'b0;
    chk("owner_after_done1", bus.feat_owner_o, 1);
    chk("dbg1", dbg1, n1);
    chk("dbg2_unchanged", dbg2, last_n2);
    chk("state_xfer", dbg3[2:0], 3);
    step;
    chk("pre_start2", bus.conv2_start_o, 0);
    step;
    chk("start2", bus.conv2_start_o, 1);
    chk("state_run2", dbg3[2:0], 4);
    for (int k = 1; k <= n2; k++) begin
      step;
      bus.conv2_first_feat_i = (k == f2a);
      bus.conv2_done_i       = (k == n2);
      bus.conv1_done_i       = spurious && (k == n2 / 2);
    end
    step;
    bus.conv2_first_feat_i = 1'b0;
    bus.conv2_done_i       = 1'b0;
    bus.conv1_done_i       = 1'b0;
    chk("ready_done", ready, 1);
    chk("owner_done", bus.feat_owner_o, 1);
    chk("dbg2", dbg2, n2);
    chk("dbg1_kept", dbg1, n1);
    chk("dbg3_done", dbg3, mk_dbg3(f1a, f2a, 1'b0, 5));
    last_n2 = n2;
    set_flags(1'b0);
    step;
    step;
    chk("ready_cleared", ready, 0);
    chk("owner_cleared", bus.feat_owner_o, 0);
    chk("state_arm", dbg3[2:0], 1);
  endtask

  initial begin
    int n1, n2, f1a, f1b, f2a, cnt;
    rst = 1'b1;
    set_flags(1'b0);
    tf = 1'b0;
    bus.conv1_done_i = 0; bus.conv2_done_i = 0;
    bus.conv1_first_feat_i = 0; bus.conv2_first_feat_i = 0;
    tbus.conv1_done_i = 0; tbus.conv2_done_i = 0;
    tbus.conv1_first_feat_i = 0; tbus.conv2_first_feat_i = 0;
    repeat (3) step;
    chk("rst_start1", bus.conv1_start_o, 0);
    chk("rst_start2", bus.conv2_start_o, 0);
    chk("rst_owner", bus.feat_owner_o, 0);
    chk("rst_ready", ready, 0);
    chk("rst_dbg1", dbg1, 0);
    chk("rst_dbg2", dbg2, 0);
    chk("rst_dbg3", dbg3, 0);
    rst = 1'b0;
    repeat (8) step;
    chk("armed", dbg3[2:0], 1);
    bus.conv1_done_i = 1'b1;
    step;
    bus.conv1_done_i = 1'b0;
    step;
    chk("arm_done_ignored_state", dbg3[2:0], 1);
    chk("arm_done_ignored_dbg1", dbg1, 0);

    set_flags(1'b1);
    do_run(500, 300, 40, 90, 150, 1'b1);

    for (int r = 0; r < 3; r++) begin
      n1  = $urandom_range(30, 400);
      f1a = $urandom_range(1, n1 / 3);
      f1b = $urandom_range(f1a + 1, n1 - 1);
      n2  = (r == 2) ? 4600 : $urandom_range(30, 300);
      f2a = (r == 2) ? $urandom_range(4100, 4500) : $urandom_range(1, n2 - 1);
      set_flags(1'b1);
      do_run(n1, n2, f1a, f1b, f2a, r[0]);
    end

    // Stale flags at reset release must not start a run.
    rst = 1'b1;
    set_flags(1'b1);
    repeat (2) step;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step;
      cnt += int'(bus.conv1_start_o);
    end
    chk("stale_no_start", cnt, 0);
    chk("stale_idle", dbg3[2:0], 0);
    set_flags(1'b0);
    repeat (3) step;
    set_flags(1'b1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step;
      cnt += int'(bus.conv1_start_o);
    end
    chk("fresh_one_start", cnt, 1);

    // Watchdog instance.
    rst = 1'b1;
    step;
    rst = 1'b0;
    repeat (3) step;
    tf = 1'b1;
    step;
    step;
    chk("t_start1", tbus.conv1_start_o, 1);
    for (int k = 1; k <= 64; k++) step;
    chk("t_run1_at_limit", t_dbg3[2:0], 2);
    step;
    chk("t_err_dbg3", t_dbg3, mk_dbg3(0, 0, 1'b1, 6));
    chk("t_err_ready", t_ready, 1);
    chk("t_err_owner", tbus.feat_owner_o, 0);
    repeat (3) step;
    chk("t_err_stays", t_dbg3[2:0], 6);
    tf = 1'b0;
    step;
    step;
    chk("t_err_to_arm", t_dbg3[3:0], 4'b1001);
    chk("t_err_ready_clr", t_ready, 0);
    tf = 1'b1;
    step;
    step;
    chk("t_restart", tbus.conv1_start_o, 1);
    chk("t_err_cleared", t_dbg3[3], 0);
    for (int k = 1; k <= 64; k++) begin
      step;
      tbus.conv1_done_i = (k == 64);
    end
    step;
    tbus.conv1_done_i = 1'b0;
    chk("t_done_wins_state", t_dbg3[3:0], 4'b0011);
    chk("t_done_wins_dbg1", t_dbg1, 64);
    repeat (2) step;
    chk("t_start2", tbus.conv2_start_o, 1);
    repeat (10) step;
    chk("t_in_run2", t_dbg3[2:0], 4);
    rst = 1'b1;
    step;
    chk("t_rst_start1", tbus.conv1_start_o, 0);
    chk("t_rst_start2", tbus.conv2_start_o, 0);
    chk("t_rst_owner", tbus.feat_owner_o, 0);
    chk("t_rst_ready", t_ready, 0);
    chk("t_rst_dbg1", t_dbg1, 0);
    chk("t_rst_dbg2", t_dbg2, 0);
    chk("t_rst_dbg3", t_dbg3, 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step;
      cnt += int'(tbus.conv1_start_o);
    end
    chk("t_no_restart", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
